// File: rtl/seq_pkg.sv
// Shared types and constants for the serial frame transmitter.
package seq_pkg;

  // Transmitter phases: idle, preamble, payload, parity bit, inter-frame gap.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    DATA = 3'd2,
    PAR  = 3'd3,
    GAP  = 3'd4
  } tx_state_t;

  // Sync pattern the downstream detectors look for, sent MSB first.
  localparam logic [3:0] DEFAULT_PREAMBLE = 4'b1101;

  // Down-counter width: must hold the longest field length minus one.
  function automatic int cnt_width(input int pre_w, input int data_w, input int gap_cycles);
    int m;
    m = pre_w;
    if (data_w > m) m = data_w;
    if (gap_cycles > m) m = gap_cycles;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-in serial-out shift register; q_msb is the next bit to send.
module piso_shreg #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         q_msb
);

  logic [W-1:0] sr_reg;

  // Load takes precedence over shift; shifting moves the next bit into the MSB.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sr_reg <= '0;
    end else if (load) begin
      sr_reg <= d;
    end else if (shift) begin
      sr_reg <= sr_reg << 1;
    end
  end

  assign q_msb = sr_reg[W-1];

endmodule

// File: rtl/seq_tx.sv
// Serial frame transmitter: preamble, payload MSB first, optional even
// parity and an idle gap, one bit per clock on Out.
module seq_tx
  import seq_pkg::*;
#(
  parameter int              DATA_W     = 8,
  parameter int              PRE_W      = 4,
  parameter logic [PRE_W-1:0] PREAMBLE  = DEFAULT_PREAMBLE,
  parameter bit              PARITY_EN  = 1'b1,
  parameter int              GAP_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  output logic              ready,
  output logic              Out,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W     = cnt_width(PRE_W, DATA_W, GAP_CYCLES);
  localparam int PRE_IDX_W = (PRE_W > 1) ? $clog2(PRE_W) : 1;

  tx_state_t            state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 out_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 parity_reg;
  logic                 handshake;
  logic                 shift;
  logic                 q_msb;
  logic [PRE_IDX_W-1:0] pre_idx;

  assign ready     = (state_reg == IDLE);
  assign handshake = valid && ready;

  // Advance the payload whenever its current MSB is being put on the line.
  assign shift = ((state_reg == PRE)  && (cnt_reg == '0)) ||
                 ((state_reg == DATA) && (cnt_reg != '0));

  // Preamble bit for the next PRE cycle, indexed straight from the pattern.
  assign pre_idx = PRE_IDX_W'(cnt_reg - 1'b1);

  piso_shreg #(.W(DATA_W)) u_payload (
    .clock (clock),
    .reset (reset),
    .load  (handshake),
    .shift (shift),
    .d     (data_in),
    .q_msb (q_msb)
  );

  // Frame sequencer; every output is registered so Out changes only at edges.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      out_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      parity_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          out_reg  <= 1'b0;
          busy_reg <= 1'b0;
          done_reg <= 1'b0;
          if (handshake) begin
            state_reg  <= PRE;
            cnt_reg    <= CNT_W'(PRE_W - 1);
            out_reg    <= PREAMBLE[PRE_W-1];
            busy_reg   <= 1'b1;
            parity_reg <= ^data_in;
          end
        end
        PRE: begin
          if (cnt_reg == '0) begin
            state_reg <= DATA;
            cnt_reg   <= CNT_W'(DATA_W - 1);
            out_reg   <= q_msb;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
            out_reg <= PREAMBLE[pre_idx];
          end
        end
        DATA: begin
          if (cnt_reg == '0) begin
            if (PARITY_EN) begin
              state_reg <= PAR;
              out_reg   <= parity_reg;
            end else begin
              state_reg <= GAP;
              cnt_reg   <= CNT_W'(GAP_CYCLES - 1);
              out_reg   <= 1'b0;
              done_reg  <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
            out_reg <= q_msb;
          end
        end
        PAR: begin
          state_reg <= GAP;
          cnt_reg   <= CNT_W'(GAP_CYCLES - 1);
          out_reg   <= 1'b0;
          done_reg  <= 1'b1;
        end
        GAP: begin
          out_reg  <= 1'b0;
          done_reg <= 1'b0;
          if (cnt_reg == '0) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          out_reg   <= 1'b0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign Out  = out_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_seq_tx.sv
// Directed bench for seq_tx: default instance plus a no-parity, one-gap instance.
module tb_seq_tx;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid;
  logic       ready, tx_out, busy, done;
  logic [7:0] data_in2;
  logic       valid2;
  logic       ready2, tx_out2, busy2, done2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done = -1;

  always #5 clock = ~clock;

  // Cycle counter used to measure spacing between done pulses.
  always @(posedge clock) cyc <= cyc + 1;

  seq_tx u_dut (
    .clock   (clock),
    .reset   (reset),
    .data_in (data_in),
    .valid   (valid),
    .ready   (ready),
    .Out     (tx_out),
    .busy    (busy),
    .done    (done)
  );

  seq_tx #(.PARITY_EN(1'b0), .GAP_CYCLES(1)) u_dut2 (
    .clock   (clock),
    .reset   (reset),
    .data_in (data_in2),
    .valid   (valid2),
    .ready   (ready2),
    .Out     (tx_out2),
    .busy    (busy2),
    .done    (done2)
  );

  // Send one frame from an IDLE cycle and check all 16 cycles that follow.
  task automatic run_frame(input logic [7:0] d, input logic [12:0] exp_bits,
                           input int spur_a, input int spur_b, input bit hold,
                           input string tag);
    logic [12:0] bits;
    logic eo, eb, ed, er;
    bits    = exp_bits;
    data_in = d;
    valid   = 1'b1;
    @(posedge clock); #1;
    for (int k = 1; k <= 16; k++) begin
      if (hold) begin
        valid = 1'b1; data_in = d;
      end else if (k == spur_a || k == spur_b) begin
        valid = 1'b1; data_in = 8'h00;
      end else begin
        valid = 1'b0; data_in = d;
      end
      eo = (k <= 13) ? bits[13-k] : 1'b0;
      eb = (k <= 15);
      ed = (k == 14);
      er = (k == 16);
      checks++;
      if (tx_out !== eo) begin
        errors++; $display("FAIL %s out cycle %0d got %b want %b", tag, k, tx_out, eo);
      end
      checks++;
      if (busy !== eb) begin
        errors++; $display("FAIL %s busy cycle %0d got %b want %b", tag, k, busy, eb);
      end
      checks++;
      if (done !== ed) begin
        errors++; $display("FAIL %s done cycle %0d got %b want %b", tag, k, done, ed);
      end
      checks++;
      if (ready !== er) begin
        errors++; $display("FAIL %s ready cycle %0d got %b want %b", tag, k, ready, er);
      end
      if (done === 1'b1) last_done = cyc;
      if (k < 16) begin
        @(posedge clock); #1;
      end
    end
    $display("frame %s data=%h done_cycle=%0d", tag, d, last_done);
  endtask

  task automatic test_reset();
    reset = 1'b0; valid = 1'b0; valid2 = 1'b0; data_in = 8'h00; data_in2 = 8'h00;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      checks++;
      if (tx_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL reset_hold out/busy/done got %b%b%b want 000", tx_out, busy, done);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ready !== 1'b1 || ready2 !== 1'b1) begin
        errors++; $display("FAIL reset_ready got %b/%b want 1/1", ready, ready2);
      end
      if (i == 0) begin
        @(posedge clock); #1;
      end
    end
    $display("reset hold complete");
  endtask

  task automatic test_single_frame();
    run_frame(8'hA5, 13'b1101_10100101_0, 0, 0, 1'b0, "single_a5");
  endtask

  task automatic test_busy_valid();
    run_frame(8'hA5, 13'b1101_10100101_0, 3, 8, 1'b0, "busy_valid");
  endtask

  task automatic test_back_to_back();
    int first_done;
    run_frame(8'h01, 13'b1101_00000001_1, 0, 0, 1'b1, "b2b_01");
    first_done = last_done;
    run_frame(8'hFF, 13'b1101_11111111_0, 0, 0, 1'b0, "b2b_ff");
    checks++;
    if (last_done - first_done !== 16) begin
      errors++; $display("FAIL b2b_done_spacing got %0d want 16", last_done - first_done);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [12:0] bits;
    bits    = 13'b1101_10100101_0;
    data_in = 8'hA5;
    valid   = 1'b1;
    @(posedge clock); #1;
    valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      checks++;
      if (tx_out !== bits[13-k]) begin
        errors++; $display("FAIL rst_mid out cycle %0d got %b want %b", k, tx_out, bits[13-k]);
      end
      if (k < 7) begin
        @(posedge clock); #1;
      end
    end
    reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (tx_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rst_mid_abort out/busy/done got %b%b%b want 000", tx_out, busy, done);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      checks++;
      if (tx_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
        errors++; $display("FAIL rst_mid_idle out/busy/done/ready got %b%b%b%b want 0001",
                           tx_out, busy, done, ready);
      end
    end
    $display("reset mid-frame aborted");
    run_frame(8'h3C, 13'b1101_00111100_0, 0, 0, 1'b0, "after_rst_3c");
  endtask

  task automatic test_no_parity();
    logic [11:0] bits;
    logic eo, eb, ed, er;
    bits     = 12'b1101_11000011;
    data_in2 = 8'hC3;
    valid2   = 1'b1;
    @(posedge clock); #1;
    valid2 = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      eo = (k <= 12) ? bits[12-k] : 1'b0;
      eb = (k <= 13);
      ed = (k == 13);
      er = (k == 14);
      checks++;
      if (tx_out2 !== eo) begin
        errors++; $display("FAIL nopar out cycle %0d got %b want %b", k, tx_out2, eo);
      end
      checks++;
      if (busy2 !== eb || done2 !== ed || ready2 !== er) begin
        errors++; $display("FAIL nopar busy/done/ready cycle %0d got %b%b%b want %b%b%b",
                           k, busy2, done2, ready2, eb, ed, er);
      end
      if (k < 14) begin
        @(posedge clock); #1;
      end
    end
    $display("frame nopar data=c3 complete");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_busy_valid();
    test_back_to_back();
    test_reset_mid_frame();
    test_no_parity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_tx.md
Name: seq_tx

Overview:
Serial frame transmitter: the generating end of the single-bit serial line that our sequence-detector FSMs consume on In.
- Accepts a parallel data word over a valid/ready handshake.
- Emits a fixed preamble, the data MSB first, an optional even-parity bit and an idle gap, one bit per clock on Out.
- Drives detector benches and on-chip serial links.

Parameters:
DATA_W, 8, payload width in bits (>=1)
PRE_W, 4, preamble width in bits (>=1)
PREAMBLE, 4'b1101, preamble pattern, sent MSB first
PARITY_EN, 1, 1 = append even-parity bit after data; 0 = omit
GAP_CYCLES, 2, idle cycles (Out=0) after each frame (>=1)

Ports:
clock  in  1  single clock; all state updates on posedge
reset  in  1  synchronous, active-low; reset==0 at a posedge clears the block
data_in  in  DATA_W  payload; sampled only on handshake
valid  in  1  producer has a word
ready  out  1  1 iff state==IDLE (combinational from state)
Out  out  1  registered serial bit
busy  out  1  registered; 1 in PRE/DATA/PAR/GAP
done  out  1  registered one-cycle pulse, frame completed

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; Out=0, busy=0, done=0; shift register and counter cleared.
  - ready=1 the following cycle.
- States:
  - IDLE -> PRE on handshake (valid&&ready at posedge).
  - PRE -> DATA after PRE_W bits.
  - DATA -> PAR after DATA_W bits when PARITY_EN=1; DATA -> GAP when PARITY_EN=0.
  - PAR -> GAP after 1 bit.
  - GAP -> IDLE after GAP_CYCLES cycles.
- Handshake edge (cycle 0):
  - Captures data_in into the shift register.
  - Computes the parity bit = ^data_in (even parity: total ones incl. parity bit even).
  - Loads Out <= PREAMBLE[PRE_W-1]; busy<=1.
  - Latency handshake->first bit = 1 cycle.
- Bit timing:
  - Cycles 1..PRE_W: PREAMBLE, MSB first.
  - Next DATA_W cycles: data MSB first.
  - Then the parity bit if enabled.
  - Then GAP_CYCLES cycles of Out=0.
  - Each bit lasts exactly one cycle; no idle between fields.
- done=1 for exactly the first GAP cycle; busy stays 1 through GAP.
- IDLE: Out=0, busy=0, done=0.
- Frame length F = PRE_W+DATA_W+PARITY_EN. done in cycle F+1; ready returns in cycle F+GAP_CYCLES+1.
- valid while busy: ignored; data_in changes while busy have no effect on the frame in flight.
- Back-to-back: a handshake in the first IDLE cycle starts the next frame.
  - Minimum frame spacing F+GAP_CYCLES+1 cycles.
  - The single IDLE cycle carries Out=0.
- Counter: $clog2 of max(PRE_W,DATA_W,GAP_CYCLES)+1 bits, counts down; field change when counter==0.
- Reset mid-frame: aborts immediately at that edge. Out=0, busy=0, no done pulse, partial frame discarded.
- Reset has priority over handshake in the same cycle.

Decomposition:
- Package seq_pkg:
  - typedef enum logic [2:0] tx_state_t {IDLE, PRE, DATA, PAR, GAP}
  - default PREAMBLE constant
  - function for counter width
- Sub-module piso_shreg:
  - parallel-in serial-out shift register, parameter W.
  - Ports clock, reset, load, shift, d[W-1:0], q_msb.
  - Instantiated once for the payload.
- The preamble is indexed directly from the parameter by the counter.

Test Plan:
All scenarios use default parameters (PREAMBLE=1101, PARITY_EN=1, GAP_CYCLES=2).
- Reset hold: reset=0 for 2 cycles, valid=0 -> Out=0, busy=0, done=0, ready=1 from first cycle after release.
- Single frame 8'hA5, valid 1 cycle at edge 0 -> Out cycles 1..13 = 1101 10100101 0.
  - Out=0 cycles 14-15; done=1 only in cycle 14; ready=1 at cycle 16.
- Back-to-back 8'h01 then 8'hFF, valid held high:
  - Second handshake at the cycle-16 edge; Out=0 in cycle 16.
  - Frame 1 data 00000001 parity 1; frame 2 data 11111111 parity 0; two done pulses 16 cycles apart.
- Busy-time valid: after 8'hA5 handshake, pulse valid with data_in=8'h00 in cycles 3 and 8 -> transmitted bits unchanged from scenario 2, ready stays 0.
- Reset mid-data: assert reset=0 at the cycle-7 edge of an 8'hA5 frame -> Out=0, busy=0 next cycle, no done.
  - Then send 8'h3C -> 1101 00111100 0, done at cycle 14.
- PARITY_EN=0, GAP_CYCLES=1, data 8'hC3 -> Out cycles 1..12 = 1101 11000011; cycle 13 Out=0 with done=1; ready=1 at cycle 14.
